// File: rtl/keypad_scanner_pkg.sv
// Shared key codes, scanner FSM states and the 4x4 keymap used by the scanner
// and by the calculator control FSM.
package keypad_scanner_pkg;

   localparam int KEY_W = 5;

   localparam logic [KEY_W-1:0] KEY_0    = 5'h00;
   localparam logic [KEY_W-1:0] KEY_1    = 5'h01;
   localparam logic [KEY_W-1:0] KEY_2    = 5'h02;
   localparam logic [KEY_W-1:0] KEY_3    = 5'h03;
   localparam logic [KEY_W-1:0] KEY_4    = 5'h04;
   localparam logic [KEY_W-1:0] KEY_5    = 5'h05;
   localparam logic [KEY_W-1:0] KEY_6    = 5'h06;
   localparam logic [KEY_W-1:0] KEY_7    = 5'h07;
   localparam logic [KEY_W-1:0] KEY_8    = 5'h08;
   localparam logic [KEY_W-1:0] KEY_9    = 5'h09;
   localparam logic [KEY_W-1:0] KEY_A    = 5'h0A;
   localparam logic [KEY_W-1:0] KEY_B    = 5'h0B;
   localparam logic [KEY_W-1:0] KEY_C    = 5'h0C;
   localparam logic [KEY_W-1:0] KEY_D    = 5'h0D;
   localparam logic [KEY_W-1:0] KEY_E    = 5'h0E;
   localparam logic [KEY_W-1:0] KEY_F    = 5'h0F;
   localparam logic [KEY_W-1:0] KEY_NONE = 5'h10;

   typedef enum logic {
      ST_SCAN,
      ST_EVAL
   } scan_state_t;

   // Physical layout of the board keypad: row r, column c.
   function automatic logic [KEY_W-1:0] keymap(input logic [1:0] r, input logic [1:0] c);
      case ({r, c})
         4'h0: return KEY_1;
         4'h1: return KEY_2;
         4'h2: return KEY_3;
         4'h3: return KEY_A;
         4'h4: return KEY_4;
         4'h5: return KEY_5;
         4'h6: return KEY_6;
         4'h7: return KEY_B;
         4'h8: return KEY_7;
         4'h9: return KEY_8;
         4'hA: return KEY_9;
         4'hB: return KEY_C;
         4'hC: return KEY_0;
         4'hD: return KEY_F;
         4'hE: return KEY_E;
         default: return KEY_D;
      endcase
   endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pin and key-code bundle between the board pins, the scanner and the
// calculator FSM.
interface keypad_scanner_if;
   import keypad_scanner_pkg::*;

   logic [3:0]       row;
   logic [3:0]       col;
   logic [KEY_W-1:0] key;
   logic             key_strobe;

   modport master (
      input  row,
      output col,
      output key,
      output key_strobe
   );

   modport slave (
      output row,
      input  col,
      input  key,
      input  key_strobe
   );
endinterface

// File: rtl/keypad_scanner_debounce.sv
// Debounce of per-scan key results into a stable key level plus press strobe.
// Auto-repeat strobes are built only when KEYPAD_AUTOREPEAT_EN is defined.
module key_debounce
   import keypad_scanner_pkg::*;
#(
   parameter int DEBOUNCE_SCANS = 4,
   parameter int REPEAT_SCANS   = 50
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             eval_valid,
   input  logic [KEY_W-1:0] scan_result,
   output logic [KEY_W-1:0] key,
   output logic             key_strobe
);

   localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

   logic [KEY_W-1:0] cand_reg, cand_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [KEY_W-1:0] key_reg;
   logic             strobe_reg;
   logic             accept;
   logic             repeat_fire;

   always_comb begin
      cand_next = cand_reg;
      cnt_next  = cnt_reg;
      if (scan_result != cand_reg) begin
         cand_next = scan_result;
         cnt_next  = CNT_W'(1);
      end else if (cnt_reg != CNT_W'(DEBOUNCE_SCANS)) begin
         cnt_next = cnt_reg + CNT_W'(1);
      end
      accept = (cnt_next == CNT_W'(DEBOUNCE_SCANS)) && (cand_next != key_reg);
   end

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int REP_W = $clog2(REPEAT_SCANS + 1);

   logic [REP_W-1:0] rep_cnt_reg;
   logic             key_matched;

   // A press keeps counting EVALs only while every scan still reports it.
   assign key_matched = (key_reg != KEY_NONE) && (scan_result == key_reg);
   assign repeat_fire = eval_valid && key_matched &&
                        (rep_cnt_reg == REP_W'(REPEAT_SCANS - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rep_cnt_reg <= '0;
      end else if (eval_valid) begin
         if (accept || !key_matched || repeat_fire)
            rep_cnt_reg <= '0;
         else
            rep_cnt_reg <= rep_cnt_reg + REP_W'(1);
      end
   end
`else
   assign repeat_fire = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cand_reg   <= KEY_NONE;
         cnt_reg    <= '0;
         key_reg    <= KEY_NONE;
         strobe_reg <= 1'b0;
      end else begin
         strobe_reg <= repeat_fire;
         if (eval_valid) begin
            cand_reg <= cand_next;
            cnt_reg  <= cnt_next;
            if (accept) begin
               key_reg    <= cand_next;
               strobe_reg <= (cand_next != KEY_NONE);
            end
         end
      end
   end

   assign key        = key_reg;
   assign key_strobe = strobe_reg;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad column scanner with row synchroniser and multi-press lockout.
// Optional auto-repeat strobes are enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_scanner
   import keypad_scanner_pkg::*;
#(
   parameter int SCAN_DIV       = 1000,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int REPEAT_SCANS   = 50
) (
   input  logic             clk,
   input  logic             rst,
   keypad_scanner_if.master bus
);

   localparam int DIV_W = $clog2(SCAN_DIV);

   logic [3:0]       row_meta_reg;
   logic [3:0]       row_sync_reg;
   scan_state_t      state_reg;
   logic [1:0]       col_idx_reg;
   logic [DIV_W-1:0] div_cnt_reg;
   logic [3:0]       col_reg;
   logic [1:0]       acc_cnt_reg;
   logic [KEY_W-1:0] acc_code_reg;

   logic [3:0]       low_vec;
   logic [2:0]       low_cnt;
   logic [1:0]       hit_row;
   logic [2:0]       acc_sum;
   logic [1:0]       acc_cnt_next;
   logic             slot_end;
   logic             eval_valid;
   logic [KEY_W-1:0] scan_result;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row_meta_reg <= 4'b1111;
         row_sync_reg <= 4'b1111;
      end else begin
         row_meta_reg <= bus.row;
         row_sync_reg <= row_meta_reg;
      end
   end

   assign low_vec = ~row_sync_reg;
   assign low_cnt = 3'($countones(low_vec));

   always_comb begin
      hit_row = 2'd0;
      for (int r = 3; r >= 0; r--)
         if (low_vec[r]) hit_row = 2'(r);
   end

   // Accumulator counts low rows across the scan, saturating at 2 (= multi-press).
   assign acc_sum      = {1'b0, acc_cnt_reg} + low_cnt;
   assign acc_cnt_next = (acc_sum > 3'd2) ? 2'd2 : acc_sum[1:0];
   assign slot_end     = (state_reg == ST_SCAN) && (div_cnt_reg == DIV_W'(SCAN_DIV - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= ST_SCAN;
         col_idx_reg  <= 2'd0;
         div_cnt_reg  <= '0;
         col_reg      <= 4'b1110;
         acc_cnt_reg  <= 2'd0;
         acc_code_reg <= KEY_NONE;
      end else begin
         case (state_reg)
            ST_SCAN: begin
               if (slot_end) begin
                  div_cnt_reg <= '0;
                  acc_cnt_reg <= acc_cnt_next;
                  if (acc_cnt_reg == 2'd0 && low_cnt == 3'd1)
                     acc_code_reg <= keymap(hit_row, col_idx_reg);
                  col_idx_reg <= col_idx_reg + 2'd1;
                  col_reg     <= {col_reg[2:0], col_reg[3]};
                  if (col_idx_reg == 2'd3)
                     state_reg <= ST_EVAL;
               end else begin
                  div_cnt_reg <= div_cnt_reg + DIV_W'(1);
               end
            end
            ST_EVAL: begin
               // Column 0 is already driven here so its rows settle early.
               state_reg    <= ST_SCAN;
               acc_cnt_reg  <= 2'd0;
               acc_code_reg <= KEY_NONE;
            end
            default: state_reg <= ST_SCAN;
         endcase
      end
   end

   assign eval_valid  = (state_reg == ST_EVAL);
   assign scan_result = (acc_cnt_reg == 2'd1) ? acc_code_reg : KEY_NONE;
   assign bus.col     = col_reg;

   key_debounce #(
      .DEBOUNCE_SCANS (DEBOUNCE_SCANS),
      .REPEAT_SCANS   (REPEAT_SCANS)
   ) u_debounce (
      .clk         (clk),
      .rst         (rst),
      .eval_valid  (eval_valid),
      .scan_result (scan_result),
      .key         (bus.key),
      .key_strobe  (bus.key_strobe)
   );

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad model drives rows from columns,
// expected key events are queued with the EVAL they must follow.
module tb_keypad_scanner;

   localparam logic [4:0] NONE = 5'h10;

   typedef struct {
      logic [4:0] key;
      logic       strobe;
      int         eval_no;
   } exp_t;

   exp_t        exp_q[$];
   int          total = 0;
   int          bad = 0;
   int          eval_cnt = 0;
   int          strobe_cnt = 0;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] pressed = 16'h0;

   keypad_scanner_if bus ();

   keypad_scanner #(
      .SCAN_DIV       (4),
      .DEBOUNCE_SCANS (3),
      .REPEAT_SCANS   (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Keypad: a pressed key at (r,c) pulls row r low while column c is driven low.
   always_comb begin
      bus.row = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r*4+c] && !bus.col[c]) bus.row[r] = 1'b0;
   end

   function automatic logic [15:0] pos(input logic [4:0] k);
      int idx;
      case (k)
         5'h1: idx = 0;  5'h2: idx = 1;  5'h3: idx = 2;  5'hA: idx = 3;
         5'h4: idx = 4;  5'h5: idx = 5;  5'h6: idx = 6;  5'hB: idx = 7;
         5'h7: idx = 8;  5'h8: idx = 9;  5'h9: idx = 10; 5'hC: idx = 11;
         5'h0: idx = 12; 5'hF: idx = 13; 5'hE: idx = 14; default: idx = 15;
      endcase
      return 16'h0001 << idx;
   endfunction

   function automatic void expect_ev(input logic [4:0] k, input logic s, input int n);
      exp_t e;
      e.key = k; e.strobe = s; e.eval_no = n;
      exp_q.push_back(e);
   endfunction

   // Monitor: detects EVAL cycles from the column sequence and pops one
   // expectation per key change or strobe seen the cycle after.
   initial begin
      logic [4:0] last_key;
      logic [3:0] prev_col;
      logic       after_eval;
      exp_t       e;
      last_key = NONE; prev_col = 4'hE; after_eval = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            last_key = NONE; prev_col = 4'hE; after_eval = 1'b0;
         end else begin
            if (bus.key !== last_key || bus.key_strobe !== 1'b0) begin
               if (bus.key_strobe === 1'b1) strobe_cnt++;
               $display("event: key=%h strobe=%b eval=%0d after_eval=%b",
                        bus.key, bus.key_strobe, eval_cnt, after_eval);
               total++;
               if (exp_q.size() == 0) begin
                  bad++;
                  $display("FAIL unexpected_event: got key=%h strobe=%b at eval %0d, required no event",
                           bus.key, bus.key_strobe, eval_cnt);
               end else begin
                  e = exp_q.pop_front();
                  if (bus.key !== e.key) begin
                     bad++;
                     $display("FAIL event_key: got %h required %h", bus.key, e.key);
                  end
                  total++;
                  if (bus.key_strobe !== e.strobe) begin
                     bad++;
                     $display("FAIL event_strobe: got %b required %b", bus.key_strobe, e.strobe);
                  end
                  total++;
                  if (!(after_eval && eval_cnt == e.eval_no)) begin
                     bad++;
                     $display("FAIL event_timing: got eval %0d (after_eval=%b) required cycle after eval %0d",
                              eval_cnt, after_eval, e.eval_no);
                  end
               end
            end
            last_key   = bus.key;
            after_eval = (bus.col == 4'b1110 && prev_col == 4'b0111);
            if (after_eval) eval_cnt++;
            prev_col = bus.col;
         end
      end
   end

   task automatic next_scan();
      int start;
      int n;
      start = eval_cnt;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (eval_cnt == start && n < 100);
      if (eval_cnt == start) begin
         total++; bad++;
         $display("FAIL scan_timeout: got no EVAL in %0d cycles, required one within 100", n);
      end
   endtask

   task automatic scans(input int n);
      for (int i = 0; i < n; i++) next_scan();
   endtask

   task automatic check_idle(input string name, input logic [4:0] k);
      @(posedge clk); #1;
      total++;
      if (bus.key !== k) begin
         bad++;
         $display("FAIL %s_key: got %h required %h", name, bus.key, k);
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL %s_pending: got %0d events outstanding required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (bus.col !== 4'b1110) begin bad++; $display("FAIL reset_col: got %b required 1110", bus.col); end
      total++;
      if (bus.key !== NONE) begin bad++; $display("FAIL reset_key: got %h required %h", bus.key, NONE); end
      total++;
      if (bus.key_strobe !== 1'b0) begin bad++; $display("FAIL reset_strobe: got %b required 0", bus.key_strobe); end
      @(posedge clk); #2;
      rst = 1'b1;
   endtask

   task automatic test_press();
      next_scan();
      pressed = pos(5'h5);
      expect_ev(5'h05, 1'b1, eval_cnt + 3);
      scans(4);
      check_idle("press5", 5'h05);
   endtask

   task automatic test_async_reset();
      int base;
      repeat (6) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      total++;
      if (bus.col !== 4'b1110) begin bad++; $display("FAIL areset_col: got %b required 1110", bus.col); end
      total++;
      if (bus.key !== NONE) begin bad++; $display("FAIL areset_key: got %h required %h", bus.key, NONE); end
      total++;
      if (bus.key_strobe !== 1'b0) begin bad++; $display("FAIL areset_strobe: got %b required 0", bus.key_strobe); end
      repeat (5) @(posedge clk);
      #2 rst = 1'b1;
      base = eval_cnt;
      expect_ev(5'h05, 1'b1, base + 3);
      scans(4);
      check_idle("areset_return", 5'h05);
   endtask

   task automatic test_release(input string name);
      pressed = 16'h0;
      expect_ev(NONE, 1'b0, eval_cnt + 3);
      scans(4);
      check_idle(name, NONE);
   endtask

   task automatic test_bounce();
      logic [4:0] pattern;
      int         base;
      pattern = 5'b11101;
      base = eval_cnt;
      expect_ev(5'h09, 1'b1, base + 5);
      for (int i = 0; i < 5; i++) begin
         pressed = pattern[i] ? pos(5'h9) : 16'h0;
         next_scan();
      end
      next_scan();
      check_idle("bounce9", 5'h09);
   endtask

   task automatic test_multi();
      pressed = pos(5'h1) | pos(5'h2);
      scans(4);
      pressed = pos(5'h1) | pos(5'h4);
      scans(4);
      check_idle("multi", NONE);
      pressed = 16'h0;
      next_scan();
   endtask

   task automatic test_change();
      pressed = pos(5'hA);
      expect_ev(5'h0A, 1'b1, eval_cnt + 3);
      scans(4);
      pressed = pos(5'hB);
      expect_ev(5'h0B, 1'b1, eval_cnt + 3);
      scans(4);
      check_idle("change_ab", 5'h0B);
   endtask

   task automatic test_hold_repeat();
      int base;
      int s0;
      int exp_strobes;
      base = eval_cnt;
      s0 = strobe_cnt;
      pressed = pos(5'hD);
      expect_ev(5'h0D, 1'b1, base + 3);
`ifdef KEYPAD_AUTOREPEAT_EN
      for (int k = 1; k <= 4; k++) expect_ev(5'h0D, 1'b1, base + 3 + 4 * k);
      exp_strobes = 5;
`else
      exp_strobes = 1;
`endif
      scans(20);
      pressed = 16'h0;
      expect_ev(NONE, 1'b0, base + 23);
      scans(4);
      check_idle("hold_d", NONE);
      total++;
      if (strobe_cnt - s0 != exp_strobes) begin
         bad++;
         $display("FAIL hold_strobes: got %0d required %0d", strobe_cnt - s0, exp_strobes);
      end
   endtask

   initial begin
      test_reset();
      test_press();
      test_async_reset();
      test_release("release5");
      test_bounce();
      test_release("release9");
      test_multi();
      test_change();
      test_release("releaseB");
      test_hold_repeat();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Drives a 4x4 hex matrix keypad and produces the debounced key code consumed by the calculator state machine.
- Output `key` is a level: 0x0–0xF while one key is stably held, `KEY_NONE` otherwise.
- Adds a one-cycle `key_strobe` on each new accepted press.
- Sits between the board keypad pins and the calculator control FSM.

Parameters:
- SCAN_DIV, 1000: clk cycles each column stays driven; minimum 2.
- DEBOUNCE_SCANS, 4: consecutive identical scan results needed to accept a change; minimum 1.
- REPEAT_SCANS, 50: scans between repeat strobes (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low (asserted when 0)
- row  in  4  keypad rows, active-low, externally pulled up, asynchronous to clk
- col  out  4  keypad columns, active-low, exactly one bit low at any time
- key  out  5  debounced key code: 0x0–0xF = hex key, `KEY_NONE` = 5'h10
- key_strobe  out  1  one-cycle pulse when `key` takes a new non-NONE value

Behaviour:
- Reset (rst=0, asynchronous):
  - col=4'b1110, key=KEY_NONE, key_strobe=0.
  - Row synchroniser flops = 4'b1111; candidate=KEY_NONE.
  - All counters = 0; FSM = SCAN, column index 0.
- Row input: 2-flop synchroniser on `row`. Only the synchronised value is used.
- FSM states: SCAN, EVAL.
  - SCAN: column c (0..3) is driven low for SCAN_DIV cycles. On the last cycle of the slot, synchronised rows are sampled into the scan accumulator. The index then advances; after c=3 the FSM goes to EVAL.
  - EVAL: lasts 1 cycle. Resolves the scan result, updates debounce state, then returns to SCAN with c=0 and accumulator cleared.
  - Scan period = 4*SCAN_DIV+1 cycles.
- Scan result:
  - Exactly one low row bit across the whole scan → code from the keymap.
  - Zero low bits → KEY_NONE.
  - Two or more low bits (multi-press / ghosting) → KEY_NONE (rollover lockout).
- Keymap, row r/col c:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- Debounce, evaluated in EVAL:
  - result != candidate → candidate=result, count=1.
  - result == candidate → count increments, saturating at DEBOUNCE_SCANS.
  - Once count == DEBOUNCE_SCANS (after update) and candidate != key → key=candidate.
  - In that same update, key_strobe=1 if candidate != KEY_NONE.
- Latency: key and key_strobe change on the cycle after EVAL. key_strobe is high for exactly 1 cycle.
- Direct key-to-key change without release (A held → B held) is accepted after debounce and strobes.
- Release (→ KEY_NONE) never strobes.
- Reset mid-scan aborts immediately. The first scan after reset starts at column 0 with a full SCAN_DIV slot.

Optional Feature:
- Macro: KEYPAD_AUTOREPEAT_EN.
- Defined: while key != KEY_NONE and the result keeps matching it, a repeat counter counts EVALs. Every REPEAT_SCANS EVALs after acceptance, key_strobe pulses 1 cycle; `key` is unchanged. The counter clears on any key change or on a mismatching scan.
- Undefined: exactly one strobe per accepted press; no repeat counter logic is synthesised.

Decomposition:
- Shared header `defines.h` holds:
  - KEY_0..KEY_F (5'h00–5'h0F), KEY_NONE (5'h10), KEY_W (5).
  - The keymap as a constant function `keymap(r,c)`.
  - The calculator FSM uses the same constants.
- One natural sub-module: `key_debounce`. It takes a scan result plus an EVAL-valid pulse and produces key, key_strobe and the repeat logic. The scanner proper keeps column drive, synchroniser and multi-press detection.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3, REPEAT_SCANS=4 → scan period 17 cycles):
- Assert rst=0 mid-scan with key=5 held → col=1110, key=5'h10, key_strobe=0 asynchronously. After release of rst, key=5 returns after 3 full scans.
- Hold row1 low only while col1 is low (key 5) from idle → key=5'h05 one cycle after the 3rd EVAL (~51 cycles); exactly one strobe.
- Key 9 bounces (present, absent, present, present, present per scan) → key stays 5'h10 until 3 consecutive matches, then key=9 with one strobe; no strobe during bounce.
- Release from key=9 → key=5'h10 after 3 scans; no strobe. Then press keys 1 and 2 together → key stays 5'h10 with no strobe.
- Key A held, then switched to B without release → key=0xB after 3 scans; second strobe issued.
- With KEYPAD_AUTOREPEAT_EN, key D held 20 scans → strobes at acceptance, then every 4 EVALs (5 total). Without the macro → exactly 1 strobe.
